// File: rtl/pixel_scheduler.sv
// Purpose: walks a Mandelbrot pixel grid column-major, dispatches pixels to NCORE cores, reorders counts to scan order.
// Latency: start -> first core_go 1 cycle; in-order head core_done -> t_start 1 cycle.
// Backpressure: at most NCORE pixels in flight beyond the emit pointer; emission waits for t_busy low.
module pixel_scheduler #(
  parameter int NCORE = 4,
  parameter int N_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         cfg_pix_x,
  input  logic [7:0]         cfg_pix_y,
  input  logic [N_BIT-1:0]   cfg_cxs,
  input  logic [N_BIT-1:0]   cfg_cys,
  input  logic [N_BIT-1:0]   cfg_dcx,
  input  logic [N_BIT-1:0]   cfg_dcy,
  output logic               busy,
  output logic               done,
  output logic [NCORE-1:0]   core_go,
  output logic [N_BIT-1:0]   core_cx,
  output logic [N_BIT-1:0]   core_cy,
  input  logic [NCORE-1:0]   core_done,
  input  logic [8*NCORE-1:0] core_count,
  output logic [7:0]         t_data,
  output logic               t_start,
  input  logic               t_busy
);

  localparam int LG = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HOLD = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  // Frame configuration and scan position
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_pix_x;
  logic [7:0]       r_pix_y;
  logic [7:0]       r_px;
  logic [7:0]       r_py;
  logic [N_BIT-1:0] r_cys;
  logic [N_BIT-1:0] r_dcx;
  logic [N_BIT-1:0] r_dcy;
  logic [N_BIT-1:0] r_cx;
  logic [N_BIT-1:0] r_cy;
  logic [15:0]      r_total;
  logic [15:0]      r_issued;
  logic [15:0]      r_emitted;
  logic             r_exhausted;

  // Core occupancy, per-core ROB tag, reorder buffer
  logic [NCORE-1:0] r_occ;
  logic [LG-1:0]    r_tag [NCORE];
  logic [7:0]       r_rob [NCORE];
  logic [NCORE-1:0] r_rob_vld;

  tx_state_t        r_tx_state;
  tx_state_t        w_tx_next;

  logic             w_start_ok;
  logic             w_zero_size;
  logic             w_free_any;
  logic [LG-1:0]    w_sel;
  logic             w_dispatch;
  logic [NCORE-1:0] w_go;
  logic [NCORE-1:0] w_accept;
  logic [NCORE-1:0] w_rob_vld_next;
  logic [15:0]      w_outstanding;
  logic [LG-1:0]    w_emit_ptr;
  logic             w_emit;
  logic             w_finish;
  logic             w_py_wrap;
  logic             w_px_last;

  // A start is only taken when idle and not in the done cycle.
  assign w_start_ok    = start && !r_busy && !r_done;
  assign w_zero_size   = (cfg_pix_x == 8'd0) || (cfg_pix_y == 8'd0);
  assign w_outstanding = r_issued - r_emitted;
  assign w_emit_ptr    = r_emitted[LG-1:0];
  assign w_py_wrap     = (r_py == r_pix_y - 8'd1);
  assign w_px_last     = (r_px == r_pix_x - 8'd1);

  // Lowest-index free core; scanning downward lets the lowest index win.
  always_comb begin
    w_free_any = 1'b0;
    w_sel      = '0;
    for (int k = NCORE - 1; k >= 0; k--) begin
      if (!r_occ[k]) begin
        w_free_any = 1'b1;
        w_sel      = LG'(k);
      end
    end
  end

  // Dispatch qualifier and one-hot go vector.
  always_comb begin
    w_dispatch = r_busy && !r_exhausted && (w_outstanding < 16'(NCORE)) && w_free_any;
    w_go       = '0;
    for (int k = 0; k < NCORE; k++) begin
      w_go[k] = w_dispatch && (w_sel == LG'(k));
    end
  end

  // Results from cores that are not occupied (e.g. left over from an aborted frame) are dropped.
  assign w_accept = core_done & r_occ;

  // Emit FSM next-state and send pulse.
  always_comb begin
    w_tx_next = r_tx_state;
    w_emit    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_rob_vld[w_emit_ptr] && !t_busy) begin
          w_emit    = 1'b1;
          w_tx_next = TX_HOLD;
        end
      end
      // The transmitter raises t_busy one cycle late, so this cycle cannot trust it.
      TX_HOLD: w_tx_next = TX_WAIT;
      TX_WAIT: begin
        if (!t_busy) begin
          w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // Valid bits after this cycle's emission and completions; the two never hit the same slot.
  always_comb begin
    w_rob_vld_next = r_rob_vld;
    if (w_emit) begin
      w_rob_vld_next[w_emit_ptr] = 1'b0;
    end
    for (int k = 0; k < NCORE; k++) begin
      if (w_accept[k]) begin
        w_rob_vld_next[r_tag[k]] = 1'b1;
      end
    end
  end

  assign w_finish = r_busy && (r_emitted == r_total) && (r_tx_state == TX_IDLE);

  assign busy    = r_busy;
  assign done    = r_done;
  assign core_go = w_go;
  assign core_cx = r_cx;
  assign core_cy = r_cy;
  assign t_start = w_emit;
  assign t_data  = r_rob[w_emit_ptr];

  // Frame setup, scan stepping, issue/emit counters and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_cys       <= '0;
      r_dcx       <= '0;
      r_dcy       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_total     <= '0;
      r_issued    <= '0;
      r_emitted   <= '0;
      r_exhausted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_pix_x     <= cfg_pix_x;
        r_pix_y     <= cfg_pix_y;
        r_cys       <= cfg_cys;
        r_dcx       <= cfg_dcx;
        r_dcy       <= cfg_dcy;
        r_cx        <= cfg_cxs;
        r_cy        <= cfg_cys;
        r_px        <= '0;
        r_py        <= '0;
        r_issued    <= '0;
        r_emitted   <= '0;
        r_exhausted <= 1'b0;
        r_total     <= 16'(cfg_pix_x) * 16'(cfg_pix_y);
        if (w_zero_size) begin
          r_done <= 1'b1;
        end else begin
          r_busy <= 1'b1;
        end
      end else if (r_busy) begin
        if (w_dispatch) begin
          r_issued <= r_issued + 16'd1;
          // py is the inner loop; coordinates wrap modulo 2^N_BIT.
          if (w_py_wrap) begin
            r_py <= '0;
            r_cy <= r_cys;
            r_px <= r_px + 8'd1;
            r_cx <= r_cx + r_dcx;
            if (w_px_last) begin
              r_exhausted <= 1'b1;
            end
          end else begin
            r_py <= r_py + 8'd1;
            r_cy <= r_cy + r_dcy;
          end
        end
        if (w_emit) begin
          r_emitted <= r_emitted + 16'd1;
        end
        if (w_finish) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Core occupancy, tag assignment and reorder-buffer writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ     <= '0;
      r_rob_vld <= '0;
      for (int k = 0; k < NCORE; k++) begin
        r_tag[k] <= '0;
        r_rob[k] <= '0;
      end
    end else begin
      r_occ     <= (r_occ & ~w_accept) | w_go;
      r_rob_vld <= w_rob_vld_next;
      if (w_dispatch) begin
        r_tag[w_sel] <= r_issued[LG-1:0];
      end
      for (int k = 0; k < NCORE; k++) begin
        if (w_accept[k]) begin
          r_rob[r_tag[k]] <= core_count[8*k +: 8];
        end
      end
    end
  end

  // Emit FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

endmodule
